// File: rtl/fa_bist_pkg.sv
// Shared types and golden arithmetic for the full-adder BIST controller.
package fa_bist_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Returns {co, s} for vec = {a, b, cin}.
  function automatic logic [1:0] fa_expect(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder; the single reference for expected sum/carry.
module fa_ref_model
  import fa_bist_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign {co, s} = fa_expect({a, b, cin});

endmodule

// File: rtl/fa_bist_ctrl.sv
// Exhaustive-vector BIST controller for a single-bit full adder.
// Optional FA_BIST_FAULT_INJ_EN adds a finj input that inverts the sampled sum before compare.
module fa_bist_ctrl
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             s,
  input  logic             co,
`ifdef FA_BIST_FAULT_INJ_EN
  input  logic             finj,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   abc_q, abc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic               seen_fail_q, seen_fail_d;

  logic s_exp, co_exp, s_cmp, mismatch;

  fa_ref_model u_ref (
    .a   (abc_q[2]),
    .b   (abc_q[1]),
    .cin (abc_q[0]),
    .s   (s_exp),
    .co  (co_exp)
  );

`ifdef FA_BIST_FAULT_INJ_EN
  assign s_cmp = s ^ finj;
`else
  assign s_cmp = s;
`endif

  // One error per vector regardless of how many bits disagree.
  assign mismatch = ({co, s_cmp} != {co_exp, s_exp});

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    abc_d       = abc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    seen_fail_d = seen_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = APPLY;
          vec_d       = '0;
          err_d       = '0;
          fail_vec_d  = '0;
          seen_fail_d = 1'b0;
        end
      end
      APPLY: begin
        abc_d   = vec_q;
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
          if (!seen_fail_q) begin
            seen_fail_d = 1'b1;
            fail_vec_d  = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      abc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      seen_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      abc_q       <= abc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      seen_fail_q <= seen_fail_d;
    end
  end

  assign {a, b, cin} = abc_q;
  assign busy        = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = done && (err_q == '0);
  assign err_cnt     = err_q;
  assign fail_vec    = fail_vec_q;

endmodule
